// File: rtl/arc_seq_ctrl.sv
// Arc segment sequencer: queues arc commands and feeds them one at a time to the
// circular interpolation engine, with pause, flush, inter-segment dwell and a watchdog.
module arc_seq_ctrl #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3,
    parameter int unsigned GAP_CYC = 2,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic          pulse_clk,
    input  logic          sys_rst_l,

    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_direct,
    input  logic [15:0]   cmd_xs,
    input  logic [15:0]   cmd_ys,
    input  logic [15:0]   cmd_xe,
    input  logic [15:0]   cmd_ye,

    input  logic          run,
    input  logic          flush,
    input  logic          err_clr,

    output logic          eng_direct,
    output logic [15:0]   eng_xs,
    output logic [15:0]   eng_ys,
    output logic [15:0]   eng_xe,
    output logic [15:0]   eng_ye,
    output logic          eng_change_readyH,
    input  logic          eng_draw_overH,

    output logic          busy,
    output logic [AW:0]   fifo_count,
    output logic [15:0]   seg_done_cnt,
    output logic          timeout_err
);

    localparam int unsigned EW   = 65;
    localparam int unsigned WDW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GW   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign cmd_ready = (r_count < (AW+1)'(DEPTH));
    // Flush takes priority over a simultaneous push.
    assign w_push    = cmd_valid && cmd_ready && !flush;
    assign w_pop     = (r_state == S_LOAD) && (r_count != '0);
    assign w_head    = r_mem[r_rptr];

    always_ff @(posedge pulse_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_direct, cmd_xs, cmd_ys, cmd_xe, cmd_ye};
        end
    end

    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [WDW-1:0] r_wd;
    logic [GW-1:0]  r_gap;
    logic           r_timeout_err;
    logic [15:0]    r_seg_done;

    logic w_issue;
    logic w_busy;
    logic w_wd_clr;
    logic w_wd_inc;
    logic w_done;
    logic w_gap_clr;
    logic w_gap_inc;
    logic w_err_set;
    logic w_err_clr;

    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_busy      = 1'b0;
        w_wd_clr    = 1'b0;
        w_wd_inc    = 1'b0;
        w_done      = 1'b0;
        w_gap_clr   = 1'b0;
        w_gap_inc   = 1'b0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                // A flush in the same cycle would leave nothing valid to load.
                if (run && (r_count != '0) && !flush) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_busy      = 1'b1;
                w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_busy      = 1'b1;
                w_issue     = 1'b1;
                w_wd_clr    = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_busy = 1'b1;
                if (eng_draw_overH) begin
                    w_done = 1'b1;
                    if (GAP_CYC == 0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_gap_clr   = 1'b1;
                        w_state_nxt = S_GAP;
                    end
                end else if (r_wd == WD_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_ERR;
                end else begin
                    w_wd_inc = 1'b1;
                end
            end
            S_GAP: begin
                w_busy = 1'b1;
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    w_err_clr   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    logic        r_eng_direct;
    logic [15:0] r_eng_xs;
    logic [15:0] r_eng_ys;
    logic [15:0] r_eng_xe;
    logic [15:0] r_eng_ye;

    // Operands change only on a load, so they stay stable for the whole segment.
    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_eng_direct <= 1'b0;
            r_eng_xs     <= '0;
            r_eng_ys     <= '0;
            r_eng_xe     <= '0;
            r_eng_ye     <= '0;
        end else if (w_pop) begin
            {r_eng_direct, r_eng_xs, r_eng_ys, r_eng_xe, r_eng_ye} <= w_head;
        end
    end

    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_wd          <= '0;
            r_gap         <= '0;
            r_timeout_err <= 1'b0;
            r_seg_done    <= '0;
        end else begin
            if (w_wd_clr) begin
                r_wd <= '0;
            end else if (w_wd_inc) begin
                r_wd <= r_wd + WDW'(1);
            end
            if (w_gap_clr) begin
                r_gap <= '0;
            end else if (w_gap_inc) begin
                r_gap <= r_gap + GW'(1);
            end
            if (w_err_set) begin
                r_timeout_err <= 1'b1;
            end else if (w_err_clr) begin
                r_timeout_err <= 1'b0;
            end
            if (w_done) begin
                r_seg_done <= r_seg_done + 16'd1;
            end
        end
    end

    assign eng_direct        = r_eng_direct;
    assign eng_xs            = r_eng_xs;
    assign eng_ys            = r_eng_ys;
    assign eng_xe            = r_eng_xe;
    assign eng_ye            = r_eng_ye;
    assign eng_change_readyH = w_issue;
    assign busy              = w_busy;
    assign fifo_count        = r_count;
    assign seg_done_cnt      = r_seg_done;
    assign timeout_err       = r_timeout_err;

endmodule

// File: doc/arc_seq_ctrl.md
Name: arc_seq_ctrl

Overview:
- Segment sequencer in front of the point-by-point circular interpolation engine.
- Queues arc commands (start point, end point, direction) from the host side in a small FIFO.
- Presents each command's operands to the engine, issues a one-cycle start strobe, and waits for the engine's done strobe.
- Adds run/pause control, FIFO flush, inter-segment dwell, completion counting and a watchdog timeout.

Parameters:
- DEPTH, 8, FIFO depth in segments; must be a power of two, at least 2.
- AW, 3, FIFO address width; equals log2(DEPTH).
- GAP_CYC, 2, pulse_clk cycles spent in dwell after each segment; 0 means no dwell state.
- TIMEOUT, 65535, maximum cycles to wait for eng_draw_overH before raising an error.

Ports:
- pulse_clk  in  1  system/step clock
- sys_rst_l  in  1  asynchronous active-low reset
- cmd_valid  in  1  host offers a segment
- cmd_ready  out  1  FIFO can accept a segment
- cmd_direct  in  1  1 = clockwise, 0 = counter-clockwise
- cmd_xs, cmd_ys, cmd_xe, cmd_ye  in  16 each  signed start/end coordinates
- run  in  1  level; 1 = consume queued segments
- flush  in  1  one-cycle pulse; empty the FIFO
- err_clr  in  1  one-cycle pulse; leave error state
- eng_direct  out  1  operand to engine
- eng_xs, eng_ys, eng_xe, eng_ye  out  16 each  signed operands to engine
- eng_change_readyH  out  1  start strobe to engine
- eng_draw_overH  in  1  engine done strobe
- busy  out  1  a segment is loaded or in progress
- fifo_count  out  AW+1  occupancy
- seg_done_cnt  out  16  segments completed since reset; wraps
- timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Interface: reset sys_rst_l, asynchronous, active-low; clock pulse_clk. All state updates on the rising edge of pulse_clk.
- Reset values:
  - all eng_* operands 0; eng_change_readyH 0
  - busy 0, fifo_count 0, seg_done_cnt 0, timeout_err 0
  - FIFO pointers 0; state S_IDLE
  - cmd_ready is 1 as soon as reset is released.
- FIFO:
  - Write when cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count < DEPTH), combinational from count. Writes while full are ignored.
  - A pop happens in S_LOAD.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - flush: pointers and count go to 0 next cycle. A push in the same cycle is dropped; flush wins. The active segment is not affected.
- States:
  - S_IDLE: busy=0. Go to S_LOAD when run=1 and fifo_count>0.
  - S_LOAD: register the head entry into eng_* and pop. busy=1. Next state is S_ISSUE.
  - S_ISSUE: eng_change_readyH=1 for exactly this cycle. Clear the watchdog. Next state is S_WAIT.
  - S_WAIT:
    - Operands are held stable.
    - On eng_draw_overH=1, increment seg_done_cnt and go to S_GAP, or to S_IDLE if GAP_CYC=0.
    - Otherwise increment the watchdog. When it reaches TIMEOUT, set timeout_err and go to S_ERR.
  - S_GAP: count GAP_CYC cycles, then go to S_IDLE. S_IDLE re-evaluates run and the FIFO.
  - S_ERR: busy=0; no issue. On err_clr, clear timeout_err and go to S_IDLE. The FIFO is retained.
- Operand hold: eng_* hold their value from S_LOAD until the next S_LOAD; they are never changed mid-segment.
- Pause: run is sampled only in S_IDLE. Dropping run mid-segment lets the segment finish, then the block stays in S_IDLE.
- A draw_overH pulse outside S_WAIT is ignored and not counted.
- Minimum spacing between successive eng_change_readyH pulses is 3+GAP_CYC cycles plus the engine run time.
- seg_done_cnt wraps from 0xFFFF to 0.
- Reset mid-operation returns to S_IDLE with the FIFO emptied. The engine is reset separately by the same sys_rst_l.

Test Plan:
- Push 1 segment (dir=1, xs=0, ys=5, xe=5, ye=0) with run=1 -> eng_* equal those values at S_LOAD+1; eng_change_readyH high exactly 1 cycle; after the model engine returns draw_overH, seg_done_cnt=1 and busy falls 2 cycles later (GAP_CYC=2).
- Push 9 segments back-to-back with run=0 -> cmd_ready falls after the 8th; fifo_count=8; 9th dropped. Raise run -> exactly 8 strobes issued, seg_done_cnt=8, operands in FIFO order.
- Push and flush in the same cycle with count=3 -> fifo_count=0 next cycle; the in-flight segment still completes and is counted.
- Drop run during S_WAIT of segment 1 of 3 -> segment 1 completes, no further strobe, fifo_count=2. Raise run -> segments 2 and 3 proceed.
- Model engine never asserts draw_overH (TIMEOUT=16) -> timeout_err=1 after 16 S_WAIT cycles, no new strobe. err_clr -> returns to S_IDLE and reissues the next queued segment.
- Assert sys_rst_l low during S_WAIT with count=4 -> all outputs at reset values immediately; after release, fifo_count=0 and no strobe.
